// File: rtl/grid_cmd_driver.sv
// grid_cmd_driver
//   Command-side initiator for the 9x9 Sudoku cell array. Two sequences:
//   - Load: accepts 81 row-major digits on in_valid/in_ready and issues one
//     LOAD strobe per cell.
//   - Readback: issues READ to each cell in row-major order, waits for the
//     cell reply (bounded by TIMEOUT) and forwards it on rd_valid/rd_ready.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start_load/start_read  sequence start requests, honoured in IDLE only
//   in_valid/in_ready      digit input handshake, in_digit is the digit
//   cmd, data_in           command and data to the addressed cell
//   data_in_rdy            one-cycle command strobe; cmd/data_in/sel hold
//                          their last driven value while it is low
//   sel_x, sel_y           addressed column / row
//   data_out, data_out_valid  reply from the addressed cell
//   rd_valid/rd_ready      readback output handshake, rd_digit is the digit
//   busy                   high whenever a sequence is in progress
//   load_done, read_done   one-cycle completion pulses
//   err                    sticky error (bad digit or read timeout)
module grid_cmd_driver #(
  parameter int unsigned N        = 9,
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [3:0]  CMD_LOAD = 4'h0,
  parameter logic [3:0]  CMD_READ = 4'h1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_load,
  input  logic       start_read,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_digit,
  output logic [3:0] cmd,
  output logic [3:0] data_in,
  output logic       data_in_rdy,
  output logic [3:0] sel_x,
  output logic [3:0] sel_y,
  input  logic [3:0] data_out,
  input  logic       data_out_valid,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [3:0] rd_digit,
  output logic       busy,
  output logic       load_done,
  output logic       read_done,
  output logic       err
);

  // Wait counter runs 0..TIMEOUT-1 across the R_WAIT cycles.
  localparam int unsigned    TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [3:0]     LAST     = 4'(N - 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    L_ACCEPT,
    L_ISSUE,
    R_ISSUE,
    R_WAIT,
    R_OUT
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    x_q, x_d;
  logic [3:0]    y_q, y_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [3:0]    data_in_q, data_in_d;
  logic [3:0]    sel_x_q, sel_x_d;
  logic [3:0]    sel_y_q, sel_y_d;
  logic [3:0]    rd_digit_q, rd_digit_d;
  logic          err_q, err_d;
  logic          load_done_q, load_done_d;
  logic          read_done_q, read_done_d;

  logic [3:0]    nx, ny;
  logic          at_last;

  // Row-major successor of the current address.
  always_comb begin
    at_last = (x_q == LAST) && (y_q == LAST);
    if (x_q == LAST) begin
      nx = '0;
      ny = (y_q == LAST) ? '0 : y_q + 4'd1;
    end else begin
      nx = x_q + 4'd1;
      ny = y_q;
    end
  end

  // The cell bus (cmd/data_in/sel) is registered and loaded on entry to an
  // issue state, so the strobe cycle already presents the final values and
  // they stay put until the next strobe.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    tmo_d       = tmo_q;
    cmd_d       = cmd_q;
    data_in_d   = data_in_q;
    sel_x_d     = sel_x_q;
    sel_y_d     = sel_y_q;
    rd_digit_d  = rd_digit_q;
    err_d       = err_q;
    load_done_d = 1'b0;
    read_done_d = 1'b0;
    in_ready    = 1'b0;
    data_in_rdy = 1'b0;
    rd_valid    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d = L_ACCEPT;
          err_d   = 1'b0;
          x_d     = '0;
          y_d     = '0;
        end else if (start_read) begin
          state_d   = R_ISSUE;
          err_d     = 1'b0;
          x_d       = '0;
          y_d       = '0;
          cmd_d     = CMD_READ;
          data_in_d = '0;
          sel_x_d   = '0;
          sel_y_d   = '0;
        end
      end

      L_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = L_ISSUE;
          cmd_d   = CMD_LOAD;
          sel_x_d = x_q;
          sel_y_d = y_q;
          if (in_digit > 4'd9) begin
            data_in_d = '0;
            err_d     = 1'b1;
          end else begin
            data_in_d = in_digit;
          end
        end
      end

      L_ISSUE: begin
        data_in_rdy = 1'b1;
        x_d         = nx;
        y_d         = ny;
        if (at_last) begin
          state_d     = IDLE;
          load_done_d = 1'b1;
        end else begin
          state_d = L_ACCEPT;
        end
      end

      R_ISSUE: begin
        data_in_rdy = 1'b1;
        tmo_d       = '0;
        state_d     = R_WAIT;
      end

      R_WAIT: begin
        // A reply arriving in the timeout cycle still wins.
        if (data_out_valid) begin
          rd_digit_d = data_out;
          state_d    = R_OUT;
        end else if (tmo_q == TMO_LAST) begin
          rd_digit_d = 4'hF;
          err_d      = 1'b1;
          state_d    = R_OUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      R_OUT: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          x_d = nx;
          y_d = ny;
          if (at_last) begin
            state_d     = IDLE;
            read_done_d = 1'b1;
          end else begin
            state_d   = R_ISSUE;
            cmd_d     = CMD_READ;
            data_in_d = '0;
            sel_x_d   = nx;
            sel_y_d   = ny;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      tmo_q       <= '0;
      cmd_q       <= '0;
      data_in_q   <= '0;
      sel_x_q     <= '0;
      sel_y_q     <= '0;
      rd_digit_q  <= '0;
      err_q       <= 1'b0;
      load_done_q <= 1'b0;
      read_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      tmo_q       <= tmo_d;
      cmd_q       <= cmd_d;
      data_in_q   <= data_in_d;
      sel_x_q     <= sel_x_d;
      sel_y_q     <= sel_y_d;
      rd_digit_q  <= rd_digit_d;
      err_q       <= err_d;
      load_done_q <= load_done_d;
      read_done_q <= read_done_d;
    end
  end

  assign cmd       = cmd_q;
  assign data_in   = data_in_q;
  assign sel_x     = sel_x_q;
  assign sel_y     = sel_y_q;
  assign rd_digit  = rd_digit_q;
  assign err       = err_q;
  assign load_done = load_done_q;
  assign read_done = read_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_grid_cmd_driver.sv
module tb_grid_cmd_driver;
  localparam logic [3:0] CMD_LOAD = 4'h0;
  localparam logic [3:0] CMD_READ = 4'h1;
  localparam int         NCELL    = 81;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       start_load = 1'b0;
  logic       start_read = 1'b0;
  logic       in_valid   = 1'b0;
  logic [3:0] in_digit   = 4'd0;
  logic       in_ready;
  logic [3:0] cmd;
  logic [3:0] data_in;
  logic       data_in_rdy;
  logic [3:0] sel_x;
  logic [3:0] sel_y;
  logic [3:0] data_out       = 4'd0;
  logic       data_out_valid = 1'b0;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [3:0] rd_digit;
  logic       busy;
  logic       load_done;
  logic       read_done;
  logic       err;

  always #5 clk = ~clk;

  grid_cmd_driver #(
    .N        (9),
    .TIMEOUT  (15),
    .CMD_LOAD (4'h0),
    .CMD_READ (4'h1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_load     (start_load),
    .start_read     (start_read),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_digit       (in_digit),
    .cmd            (cmd),
    .data_in        (data_in),
    .data_in_rdy    (data_in_rdy),
    .sel_x          (sel_x),
    .sel_y          (sel_y),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_digit       (rd_digit),
    .busy           (busy),
    .load_done      (load_done),
    .read_done      (read_done),
    .err            (err)
  );

  // Written by the stimulus process only.
  int         seq_id      = 0;
  int         seq_kind    = 0;   // 1 = load, 2 = readback
  int         spacing     = 0;   // expected strobe-to-strobe distance, 0 = unchecked
  int         silent_idx  = -1;  // cell index that never replies
  logic [3:0] src [NCELL];
  int         end_tag     = 0;
  logic       exp_err_end = 1'b0;
  int         bound_tag   = 0;

  // Written by the cell model only.
  int         rq_tag_l = 0;
  logic       rq_pend  = 1'b0;
  logic [3:0] rq_val_l = 4'd0;
  logic       rq_sil_l = 1'b0;

  // Written by the compare process only.
  int         cyc = 0, n_checks = 0, n_err = 0;
  int         k = 0, rk = 0, ld_cnt = 0, rd_cnt = 0;
  int         last_seq = 0, last_end = 0, last_bound = 0;
  int         last_strobe = 0, last_rstrobe = 0, hs_cyc = 0;
  logic       m_err = 1'b0;
  logic [3:0] exp_grid [NCELL];
  logic [3:0] cells [NCELL];
  int         rq_tag = 0;
  logic [3:0] rq_val = 4'd0;
  logic       rq_sil = 1'b0;
  logic [15:0] p_bus = 16'd0, e16;
  logic       p_rv = 1'b0, p_rr = 1'b0;
  logic [3:0] p_rd = 4'd0, e4;
  int         cidx;

  function automatic logic [3:0] sanitize(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d, seq %0d)", name, got, exp, cyc, seq_id);
    end
  endfunction

  // Cell array model: a READ seen in cycle c is answered in cycle c+2.
  always @(posedge clk) begin
    #1;
    if (rq_pend && !rq_sil_l) begin
      data_out_valid = 1'b1;
      data_out       = rq_val_l;
    end else begin
      data_out_valid = 1'b0;
      data_out       = 4'($urandom_range(0, 15));
    end
    rq_pend = 1'b0;
    if (rq_tag != rq_tag_l) begin
      rq_tag_l = rq_tag;
      rq_pend  = 1'b1;
      rq_val_l = rq_val;
      rq_sil_l = rq_sil;
    end
  end

  // Compare process: samples every falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (seq_id != last_seq) begin
      last_seq = seq_id;
      k = 0; rk = 0; ld_cnt = 0; rd_cnt = 0; m_err = 1'b0;
    end
    if (bound_tag != last_bound) begin
      last_bound = bound_tag;
      n_checks++;
      n_err++;
      $display("FAIL wait_bound: sequence %0d did not finish within its cycle budget", seq_id);
    end
    if (!rst_n) begin
      chk("reset_outputs", 32'({in_ready, cmd, data_in, data_in_rdy, sel_x, sel_y, rd_valid,
                                rd_digit, busy, load_done, read_done, err}), 32'd0);
    end else begin
      if (!data_in_rdy)
        chk("bus_hold", 32'({cmd, data_in, sel_x, sel_y}), 32'(p_bus));
      if (data_in_rdy) begin
        chk("strobe_busy", 32'(busy), 32'd1);
        chk("strobe_not_in_rout", 32'(rd_valid), 32'd0);
        if (k >= NCELL) begin
          chk("strobe_overflow", 32'(k), 32'(NCELL - 1));
        end else begin
          cidx = int'(sel_y) * 9 + int'(sel_x);
          if (seq_kind == 1) begin
            if (src[k] > 4'd9) m_err = 1'b1;
            e16 = {CMD_LOAD, sanitize(src[k]), 4'(k % 9), 4'(k / 9)};
            chk("load_strobe", 32'({cmd, data_in, sel_x, sel_y}), 32'(e16));
            chk("load_err", 32'(err), 32'(m_err));
            if (seq_id == 1 && k == 13)
              chk("load_lit_k13", 32'({cmd, data_in, sel_x, sel_y}), 32'h0541);
            if (seq_id == 3 && k == 21)
              chk("load_lit_badc", 32'({cmd, data_in, sel_x, sel_y}), 32'h0032);
            exp_grid[k] = sanitize(src[k]);
            if (cidx < NCELL) cells[cidx] = data_in;
          end else begin
            e16 = {CMD_READ, 4'd0, 4'(k % 9), 4'(k / 9)};
            chk("read_strobe", 32'({cmd, data_in, sel_x, sel_y}), 32'(e16));
            chk("read_err", 32'(err), 32'(m_err));
            rq_val = (cidx < NCELL) ? cells[cidx] : 4'd0;
            rq_sil = (cidx == silent_idx);
            rq_tag = rq_tag + 1;
            last_rstrobe = cyc;
          end
          if (spacing != 0 && k > 0)
            chk("strobe_spacing", 32'(cyc - last_strobe), 32'(spacing));
          last_strobe = cyc;
          k = k + 1;
        end
      end
      if (in_ready) chk("in_ready_busy", 32'(busy), 32'd1);
      if (p_rv && !p_rr) begin
        chk("rd_valid_hold", 32'(rd_valid), 32'd1);
        chk("rd_digit_hold", 32'(rd_digit), 32'(p_rd));
      end
      if (rd_valid) begin
        chk("rd_busy", 32'(busy), 32'd1);
        if (!p_rv && rk < NCELL) begin
          chk("rd_latency", 32'(cyc - last_rstrobe), (rk == silent_idx) ? 32'd16 : 32'd3);
          if (rk == silent_idx) m_err = 1'b1;
          e4 = (rk == silent_idx) ? 4'hF : exp_grid[rk];
          chk("rd_digit", 32'(rd_digit), 32'(e4));
          chk("rd_err", 32'(err), 32'(m_err));
          if (seq_id == 2 && rk == 0)  chk("rd_lit_first", 32'(rd_digit), 32'd1);
          if (seq_id == 2 && rk == 40) chk("rd_lit_c40", 32'(rd_digit), 32'd5);
          if (seq_id == 4 && rk == 40) chk("rd_lit_timeout", 32'(rd_digit), 32'hF);
        end
        if (rd_ready) begin
          hs_cyc = cyc;
          rk = rk + 1;
        end
      end
      if (load_done) begin
        chk("load_done_timing", 32'({k == NCELL, (cyc - last_strobe) == 1, busy, seq_kind == 1}), 32'b1101);
        ld_cnt = ld_cnt + 1;
      end
      if (read_done) begin
        chk("read_done_timing", 32'({rk == NCELL, (cyc - hs_cyc) == 1, busy, seq_kind == 2}), 32'b1101);
        rd_cnt = rd_cnt + 1;
      end
    end
    if (end_tag != last_end) begin
      last_end = end_tag;
      chk("end_strobes", 32'(k), 32'(NCELL));
      chk("end_done_pulses", 32'(ld_cnt + rd_cnt), 32'd1);
      chk("end_err", 32'(err), 32'(exp_err_end));
      chk("end_idle", 32'({busy, in_ready, rd_valid}), 32'd0);
      if (seq_kind == 2) chk("end_handshakes", 32'(rk), 32'(NCELL));
    end
    p_bus = {cmd, data_in, sel_x, sel_y};
    p_rv  = rd_valid;
    p_rr  = rd_ready;
    p_rd  = rd_digit;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input bit full_rate, input int abort_at, input bit both);
    int  i = 0;
    int  budget = 0;
    bit  acc;
    seq_kind   = 1;
    seq_id     = seq_id + 1;
    start_load = 1'b1;
    start_read = both;
    in_valid   = full_rate;
    in_digit   = src[0];
    tick();
    start_load = 1'b0;
    start_read = 1'b0;
    while (ld_cnt == 0 && budget < 3000) begin
      if (abort_at >= 0 && k >= abort_at) break;
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) i++;
      if (i < NCELL) begin
        in_valid = full_rate ? 1'b1 : ($urandom_range(0, 2) != 0);
        in_digit = in_valid ? src[i] : 4'($urandom_range(0, 15));
      end else begin
        in_valid = 1'b0;
      end
      if (!full_rate && i > 0 && i < NCELL - 1) begin
        start_load = ($urandom_range(0, 7) == 0);
        start_read = ($urandom_range(0, 7) == 0);
      end else begin
        start_load = 1'b0;
        start_read = 1'b0;
      end
      budget++;
    end
    in_valid   = 1'b0;
    start_load = 1'b0;
    start_read = 1'b0;
    if (budget >= 3000) bound_tag = bound_tag + 1;
  endtask

  task automatic run_read(input bit random_mode);
    int budget = 0;
    int stall  = 0;
    seq_kind   = 2;
    seq_id     = seq_id + 1;
    start_read = 1'b1;
    rd_ready   = 1'b1;
    tick();
    start_read = 1'b0;
    while (rd_cnt == 0 && budget < 5000) begin
      tick();
      if (random_mode) begin
        if (rd_valid && rk == 9 && stall < 10) begin
          rd_ready = 1'b0;
          stall++;
        end else begin
          rd_ready = ($urandom_range(0, 3) != 0);
        end
        start_load = (rk < NCELL - 1) && ($urandom_range(0, 7) == 0);
        start_read = (rk < NCELL - 1) && ($urandom_range(0, 7) == 0);
      end
      budget++;
    end
    rd_ready   = 1'b0;
    start_load = 1'b0;
    start_read = 1'b0;
    if (budget >= 5000) bound_tag = bound_tag + 1;
  endtask

  task automatic finish_seq(input logic e);
    exp_err_end = e;
    end_tag     = end_tag + 1;
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NCELL; i++) src[i] = 4'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Full-rate load of 1..9 per row.
    for (int i = 0; i < NCELL; i++) src[i] = 4'((i % 9) + 1);
    spacing = 2;
    run_load(1'b1, -1, 1'b0);
    finish_seq(1'b0);

    // Readback with rd_ready held high.
    spacing = 4;
    run_read(1'b0);
    finish_seq(1'b0);

    // Random digits, bursty in_valid, illegal digit at (3,2).
    for (int i = 0; i < NCELL; i++) src[i] = 4'($urandom_range(0, 9));
    src[21] = 4'hC;
    spacing = 0;
    run_load(1'b0, -1, 1'b0);
    finish_seq(1'b1);

    // Readback with (4,4) silent, random back-pressure and a long stall at (0,1).
    silent_idx = 40;
    run_read(1'b1);
    finish_seq(1'b1);
    silent_idx = -1;

    // Both starts together, then reset partway through.
    for (int i = 0; i < NCELL; i++) src[i] = 4'($urandom_range(1, 9));
    spacing = 2;
    run_load(1'b1, 40, 1'b1);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Fresh load after the abort starts again from (0,0).
    for (int i = 0; i < NCELL; i++) src[i] = 4'($urandom_range(0, 9));
    run_load(1'b1, -1, 1'b0);
    finish_seq(1'b0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/grid_cmd_driver.md
Name: grid_cmd_driver

Overview:
- Command-side initiator for the Sudoku cell array: it drives the cell command bus that each cell receives.
- Load mode: accepts a row-major stream of 81 puzzle digits and issues one LOAD command per cell, addressed by (x,y).
- Readback mode: issues READ to each cell in row-major order, captures the cell reply and forwards it on an output stream.
- Sits between the host/UART front-end and the 9x9 cell grid.

Parameters:
- N, 9, grid dimension; cells addressed x,y in 0..N-1.
- TIMEOUT, 15, max cycles to wait for data_out_valid after a READ strobe.
- CMD_LOAD, 4'h0, command code for load-value.
- CMD_READ, 4'h1, command code for read-value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_load  in  1  start load sequence (sampled in IDLE).
- start_read  in  1  start readback sequence (sampled in IDLE).
- in_valid  in  1  input digit valid.
- in_ready  out  1  driver can accept a digit.
- in_digit  in  4  puzzle digit, 0 = empty, 1..9 = given.
- cmd  out  4  command to the addressed cell.
- data_in  out  4  data to the addressed cell.
- data_in_rdy  out  1  one-cycle command strobe.
- sel_x  out  4  addressed column.
- sel_y  out  4  addressed row.
- data_out  in  4  muxed reply value from the addressed cell.
- data_out_valid  in  1  reply valid from the addressed cell.
- rd_valid  out  1  readback digit valid.
- rd_ready  in  1  downstream accepts readback digit.
- rd_digit  out  4  readback digit.
- busy  out  1  high in any state other than IDLE.
- load_done  out  1  one-cycle pulse after the 81st LOAD strobe.
- read_done  out  1  one-cycle pulse after the 81st readback handshake.
- err  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0, state IDLE, x/y counters 0, timeout counter 0. Reset mid-sequence aborts immediately; no partial strobe completes.
- FSM states: IDLE, L_ACCEPT, L_ISSUE, R_ISSUE, R_WAIT, R_OUT.
- IDLE:
  - start_load -> L_ACCEPT, clear err, x=y=0.
  - Otherwise start_read -> R_ISSUE, clear err, x=y=0.
  - Both asserted the same cycle: load wins.
  - start_* outside IDLE is ignored.
- L_ACCEPT:
  - in_ready=1.
  - On in_valid&in_ready: register digit -> L_ISSUE.
  - Digit > 9: register 0 instead and set err.
- L_ISSUE (exactly 1 cycle):
  - Drives cmd=CMD_LOAD, data_in=registered digit, sel_x=x, sel_y=y, data_in_rdy=1; in_ready=0.
  - Then advance the address.
  - If (x,y)==(N-1,N-1): pulse load_done next cycle and go to IDLE; else go to L_ACCEPT.
- Address advance: x increments, wrapping 8->0 with y+1. Row-major, 81 commands per sequence.
- R_ISSUE (1 cycle): drives cmd=CMD_READ, sel_x/sel_y, data_in=0, data_in_rdy=1 -> R_WAIT, timeout counter cleared.
- R_WAIT:
  - sel_x/sel_y held; data_in_rdy=0.
  - data_out_valid=1 -> capture data_out into rd_digit -> R_OUT.
  - If the counter reaches TIMEOUT first: rd_digit=4'hF, set err -> R_OUT.
  - data_out_valid in the same cycle as the timeout: the valid reply wins.
- R_OUT:
  - rd_valid=1; rd_digit held stable until rd_ready.
  - On rd_valid&rd_ready: advance the address; last cell -> pulse read_done, go to IDLE; else -> R_ISSUE.
- cmd/data_in/sel hold their last driven value when data_in_rdy=0; cells must qualify on data_in_rdy only.
- Minimum per-cell latency:
  - Load: 2 cycles/cell with in_valid held high.
  - Read: 3 cycles/cell plus reply latency, with rd_ready held high.
- busy=0 exactly in IDLE. err clears only on reset or on an accepted start.

Test Plan:
- Reset, start_load, stream digits 1..9 repeated 9 times with in_valid held high -> 81 data_in_rdy strobes spaced 2 cycles apart; strobe k has sel=(k%9, k/9), data_in=(k%9)+1; load_done pulses once after strobe 80; err=0.
- Load with in_valid toggling randomly and digit 4'hC at cell (3,2) -> that strobe carries data_in=0; err=1 at end; strobe count remains 81.
- start_read with a cell model replying data_out=x+1 two cycles after each READ, rd_ready held high -> rd_digit sequence 1..9 x9; read_done pulses once after the 81st handshake.
- Readback with cell (4,4) never replying -> after TIMEOUT=15 cycles rd_digit=4'hF, err=1; the remaining 80 cells still read correctly.
- rd_ready held low for 10 cycles at cell (0,1) -> rd_valid and rd_digit stable throughout; no new READ strobe until the handshake completes.
- start_load and start_read asserted together -> load sequence runs. Assert rst_n low at cell 40 -> all outputs 0 and IDLE next edge; a new start_load begins at (0,0).
